// File: rtl/axis_route_ctrl_1x2.sv
// Packet-boundary-safe route sequencer for a 1x2 AXI-Stream switch.
// Optional stall timeout is enabled by defining AXIS_ROUTE_CTRL_TIMEOUT_EN.
module axis_route_ctrl_1x2 #(
  parameter logic [1:0]  RST_ROUTE = 2'b01,
  parameter int unsigned CNTW      = 16,
  parameter int unsigned TOUT_CYC  = 1024
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [1:0]      route_req,
  input  logic            route_req_vld,
  input  logic            mon_tvalid,
  input  logic            mon_tready,
  input  logic            mon_tlast,
  input  logic            cnt_clr,
  output logic            m0_en,
  output logic            m1_en,
  output logic            busy,
  output logic            pend,
  output logic [CNTW-1:0] pkt_cnt0,
  output logic [CNTW-1:0] pkt_cnt1,
  output logic            tout_evt
);

  typedef enum logic [0:0] {StIdle, StPkt} state_e;

  state_e          state_q;
  logic            pend_q;
  logic [1:0]      pend_route_q;
  logic [1:0]      route_q;
  logic [CNTW-1:0] cnt0_q, cnt1_q;

  logic beat, eop, apply, force_idle;

  assign beat  = mon_tvalid & mon_tready;
  assign eop   = beat & mon_tlast;
  // Only switch between packets: idle with no beat starting, or on the tlast beat itself.
  assign apply = pend_q & (((state_q == StIdle) & ~beat) | eop);

`ifdef AXIS_ROUTE_CTRL_TIMEOUT_EN
  localparam int unsigned SW = (TOUT_CYC > 1) ? $clog2(TOUT_CYC) : 1;

  logic [SW-1:0] stall_q;
  logic          stall;
  logic          tout_q;

  assign stall      = (state_q == StPkt) & pend_q & ~beat;
  assign force_idle = stall & (stall_q == SW'(TOUT_CYC - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      tout_q <= force_idle;
      if (stall && !force_idle) begin
        stall_q <= stall_q + 1'b1;
      end else begin
        stall_q <= '0;
      end
    end
  end

  assign tout_evt = tout_q;
`else
  assign force_idle = 1'b0;
  assign tout_evt   = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      pend_q       <= 1'b0;
      pend_route_q <= 2'b00;
      route_q      <= RST_ROUTE;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (beat && !mon_tlast) state_q <= StPkt;
        StPkt:  if (eop || force_idle) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      // A strobe coincident with an apply leaves the new request pending.
      if (apply) route_q <= pend_route_q;
      if (route_req_vld) begin
        pend_route_q <= route_req;
        pend_q       <= 1'b1;
      end else if (apply) begin
        pend_q <= 1'b0;
      end

      if (cnt_clr) begin
        cnt0_q <= '0;
        cnt1_q <= '0;
      end else if (eop) begin
        if (route_q[0] && !(&cnt0_q)) cnt0_q <= cnt0_q + 1'b1;
        if (route_q[1] && !(&cnt1_q)) cnt1_q <= cnt1_q + 1'b1;
      end
    end
  end

  assign m0_en    = route_q[0];
  assign m1_en    = route_q[1];
  assign busy     = (state_q == StPkt);
  assign pend     = pend_q;
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_axis_route_ctrl_1x2.sv
// Self-checking bench for axis_route_ctrl_1x2: vector table, directed sequences and
// randomized traffic against a packet-level reference model.
module tb_axis_route_ctrl_1x2;

  localparam int CNTW = 4;
  localparam int TOUT = 8;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [1:0]      route_req = 2'b00;
  logic            route_req_vld = 1'b0;
  logic            mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0, cnt_clr = 1'b0;
  logic            m0_en, m1_en, busy, pend, tout_evt;
  logic [CNTW-1:0] pkt_cnt0, pkt_cnt1;

  axis_route_ctrl_1x2 #(
    .RST_ROUTE(2'b01),
    .CNTW     (CNTW),
    .TOUT_CYC (TOUT)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .route_req    (route_req),
    .route_req_vld(route_req_vld),
    .mon_tvalid   (mon_tvalid),
    .mon_tready   (mon_tready),
    .mon_tlast    (mon_tlast),
    .cnt_clr      (cnt_clr),
    .m0_en        (m0_en),
    .m1_en        (m1_en),
    .busy         (busy),
    .pend         (pend),
    .pkt_cnt0     (pkt_cnt0),
    .pkt_cnt1     (pkt_cnt1),
    .tout_evt     (tout_evt)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: packet-level view of the route sequencer.
  logic [1:0] m_route, m_pr;
  bit         m_pend, m_inpkt, m_tevt;
  int         m_c0, m_c1, m_scnt;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_route = 2'b01; m_pr = 2'b00; m_pend = 0; m_inpkt = 0;
    m_tevt = 0; m_c0 = 0; m_c1 = 0; m_scnt = 0;
  endtask

  task automatic model_clock();
    bit beat, eop, apply, stall;
    beat  = mon_tvalid && mon_tready;
    eop   = beat && mon_tlast;
    apply = m_pend && ((!m_inpkt && !beat) || eop);
    stall = m_inpkt && m_pend && !beat;
    if (cnt_clr) begin
      m_c0 = 0; m_c1 = 0;
    end else if (eop) begin
      if (m_route[0] && m_c0 < CMAX) m_c0++;
      if (m_route[1] && m_c1 < CMAX) m_c1++;
    end
    if (apply) m_route = m_pr;
    if (route_req_vld) begin
      m_pend = 1; m_pr = route_req;
    end else if (apply) begin
      m_pend = 0;
    end
    if (!m_inpkt && beat && !mon_tlast) m_inpkt = 1;
    else if (m_inpkt && eop) m_inpkt = 0;
    m_tevt = 0;
`ifdef AXIS_ROUTE_CTRL_TIMEOUT_EN
    if (stall) begin
      m_scnt++;
      if (m_scnt == TOUT) begin
        m_inpkt = 0; m_tevt = 1; m_scnt = 0;
      end
    end else begin
      m_scnt = 0;
    end
`else
    m_scnt = stall ? m_scnt + 1 : 0;
`endif
  endtask

  task automatic check_all();
    chk("m0_en", int'(m0_en), int'(m_route[0]));
    chk("m1_en", int'(m1_en), int'(m_route[1]));
    chk("busy", int'(busy), int'(m_inpkt));
    chk("pend", int'(pend), int'(m_pend));
    chk("pkt_cnt0", int'(pkt_cnt0), m_c0);
    chk("pkt_cnt1", int'(pkt_cnt1), m_c1);
    chk("tout_evt", int'(tout_evt), int'(m_tevt));
  endtask

  task automatic step(input logic v, input logic r, input logic l, input logic vld,
                      input logic [1:0] req, input logic clr);
    mon_tvalid = v; mon_tready = r; mon_tlast = l;
    route_req_vld = vld; route_req = req; cnt_clr = clr;
    @(posedge aclk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic do_reset(input int ncyc);
    aresetn = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      mon_tvalid = 1'($urandom); mon_tready = 1'($urandom); mon_tlast = 1'($urandom);
      route_req_vld = 1'($urandom); route_req = 2'($urandom); cnt_clr = 1'($urandom);
      @(posedge aclk);
      #1;
    end
    model_reset();
    check_all();
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0; route_req_vld = 0; cnt_clr = 0;
    aresetn = 1'b1;
  endtask

  typedef struct {
    logic       v, r, l, vld;
    logic [1:0] req;
    logic [1:0] route;
    logic       pend, busy;
    int         c0;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Idle switch request, then a 4-beat packet on m0 with a mid-packet request.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 2'b01, 1'b1, 1'b1, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1};

    model_reset();
    do_reset(5);
    chk("rst_m0", int'(m0_en), 1);
    chk("rst_m1", int'(m1_en), 0);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].r, tbl[i].l, tbl[i].vld, tbl[i].req, 1'b0);
      chk($sformatf("tbl%0d_route", i), int'({m1_en, m0_en}), int'(tbl[i].route));
      chk($sformatf("tbl%0d_pend", i), int'(pend), int'(tbl[i].pend));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_cnt0", i), int'(pkt_cnt0), tbl[i].c0);
    end

    // Reset asserted mid-packet with a request pending.
    step(1, 1, 0, 0, 2'b00, 0);
    step(0, 0, 0, 1, 2'b11, 0);
    aresetn = 1'b0;
    #2;
    model_reset();
    check_all();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pend", int'(pend), 0);
    chk("midrst_route", int'({m1_en, m0_en}), 1);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Back-to-back 2-beat packets; broadcast requested during packet A.
    do_reset(2);
    step(1, 1, 0, 1, 2'b11, 0);
    step(1, 1, 1, 0, 2'b00, 0);
    chk("b2b_route_after_A", int'({m1_en, m0_en}), 3);
    step(1, 1, 0, 0, 2'b00, 0);
    step(1, 1, 1, 0, 2'b00, 0);
    chk("b2b_cnt0", int'(pkt_cnt0), 2);
    chk("b2b_cnt1", int'(pkt_cnt1), 1);

    // Saturation and clear-over-increment.
    do_reset(2);
    for (int i = 0; i < 17; i++) step(1, 1, 1, 0, 2'b00, 0);
    chk("sat_cnt0", int'(pkt_cnt0), 15);
    step(1, 1, 1, 0, 2'b00, 1);
    chk("clr_cnt0", int'(pkt_cnt0), 0);

    // Stall mid-packet with a pending request.
    do_reset(2);
    step(1, 1, 0, 0, 2'b00, 0);
    step(0, 0, 0, 1, 2'b10, 0);
    for (int i = 0; i < TOUT; i++) step(1, 0, 0, 0, 2'b00, 0);
`ifdef AXIS_ROUTE_CTRL_TIMEOUT_EN
    chk("tout_pulse", int'(tout_evt), 1);
    chk("tout_busy", int'(busy), 0);
    chk("tout_route_hold", int'({m1_en, m0_en}), 1);
    step(1, 0, 0, 0, 2'b00, 0);
    chk("tout_route_new", int'({m1_en, m0_en}), 2);
    chk("tout_cnt0", int'(pkt_cnt0), 0);
`else
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 2'b00, 0);
    chk("stall_route_hold", int'({m1_en, m0_en}), 1);
    chk("stall_busy", int'(busy), 1);
    chk("stall_tout", int'(tout_evt), 0);
`endif

    // Randomized traffic against the model.
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
           2'($urandom), 1'($urandom_range(0, 31) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
